// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and elaboration-time helpers for the VGA raster timing
//   generator.
//   - Default 640x480@60 segment lengths (25 MHz pixel from a 50 MHz clock).
//   - clog2()     : bits needed to hold 0..value-1.
//   - seg_total() : line/frame length from the four segment lengths.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIX_DIV  = 2;

  // Number of bits needed to represent 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int seg_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
//   Control and raster-timing bundle between the timing generator and the
//   downstream video stages.
//   master (generator) : in  en, resync
//                        out pix_ce, x, y, hsync, vsync, de,
//                            line_start, frame_start
//   slave  (consumer)  : mirror image of master
// -----------------------------------------------------------------------------
interface vga_timing_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           en;
  logic           resync;
  logic           pix_ce;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic           line_start;
  logic           frame_start;

  modport master (
    input  en, resync,
    output pix_ce, x, y, hsync, vsync, de, line_start, frame_start
  );

  modport slave (
    output en, resync,
    input  pix_ce, x, y, hsync, vsync, de, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_axis.sv
// -----------------------------------------------------------------------------
// vga_timing_axis
//   One raster axis (horizontal or vertical): a wrapping position counter with
//   registered sync and active decodes of the position it holds.
//   clk, rst  : clock, asynchronous active-high reset (-> last position)
//   i_step    : advance one position
//   i_clear   : jump to position 0 (wins over i_step)
//   o_cnt     : current position, 0..TOTAL-1
//   o_sync    : sync level for o_cnt, active level POL
//   o_active  : o_cnt lies in the visible region
//   o_wrap    : o_cnt is the last position (next step wraps to 0)
// -----------------------------------------------------------------------------
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int W      = clog2(seg_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_step,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt,
  output logic         o_sync,
  output logic         o_active,
  output logic         o_wrap
);

  localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
  localparam int WE    = W + 1;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  // Region bounds carry one spare bit so an end bound equal to TOTAL can
  // never alias back onto a small position.
  localparam logic [W:0]   ACTIVE_END = WE'(ACTIVE);
  localparam logic [W:0]   SYNC_START = WE'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_END   = WE'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_cnt;
  logic         r_sync;
  logic         r_active;
  logic         w_wrap;
  logic [W-1:0] w_cnt_next;

  function automatic logic sync_level(input logic [W-1:0] pos);
    logic in_sync;
    in_sync = ({1'b0, pos} >= SYNC_START) && ({1'b0, pos} < SYNC_END);
    return in_sync ? POL : ~POL;
  endfunction

  function automatic logic is_active(input logic [W-1:0] pos);
    return {1'b0, pos} < ACTIVE_END;
  endfunction

  assign w_wrap     = (r_cnt == LAST);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;

  // Decodes are taken from the position being loaded, so counter, sync and
  // active all change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= LAST;
      r_sync   <= ~POL;
      r_active <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_sync   <= sync_level('0);
      r_active <= is_active('0);
    end else if (i_step) begin
      r_cnt    <= w_cnt_next;
      r_sync   <= sync_level(w_cnt_next);
      r_active <= is_active(w_cnt_next);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_sync   = r_sync;
  assign o_active = r_active;
  assign o_wrap   = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator: pixel divider, horizontal axis
//   stepped by the pixel enable, vertical axis stepped by the horizontal wrap,
//   and registered pix_ce / line_start / frame_start strobes.
//   clk   : system clock
//   rst   : asynchronous active-high reset (position = last pixel of frame)
//   vid   : master side of vga_timing_if
//           in  en (0 freezes everything), resync (restart at pixel 0,0)
//           out pix_ce, x, y, hsync, vsync, de, line_start, frame_start
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vid
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int X_W     = clog2(H_TOTAL);
  localparam int Y_W     = clog2(V_TOTAL);
  localparam int DIV_W   = (PIX_DIV > 1) ? clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_step;
  logic             w_v_step;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_h_active;
  logic             w_v_active;
  logic             w_h_wrap;
  logic             w_v_wrap;

  // resync is excluded here so it overrides a step due in the same clk.
  assign w_step   = vid.en && !vid.resync && (r_div == DIV_LAST);
  assign w_v_step = w_step && w_h_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_pix_ce      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (vid.resync) begin
      // The jump to (0,0) counts as a step: all strobes fire, divider restarts.
      r_div         <= '0;
      r_pix_ce      <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (vid.en) begin
      r_div         <= w_step ? '0 : r_div + 1'b1;
      r_pix_ce      <= w_step;
      r_line_start  <= w_v_step;
      r_frame_start <= w_v_step && w_v_wrap;
    end else begin
      r_pix_ce      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  vga_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .W      (X_W)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .i_step   (w_step),
    .i_clear  (vid.resync),
    .o_cnt    (w_x),
    .o_sync   (w_hsync),
    .o_active (w_h_active),
    .o_wrap   (w_h_wrap)
  );

  // Stepping only on the horizontal wrap gives vsync whole-line granularity.
  vga_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .W      (Y_W)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .i_step   (w_v_step),
    .i_clear  (vid.resync),
    .o_cnt    (w_y),
    .o_sync   (w_vsync),
    .o_active (w_v_active),
    .o_wrap   (w_v_wrap)
  );

  assign vid.pix_ce      = r_pix_ce;
  assign vid.x           = w_x;
  assign vid.y           = w_y;
  assign vid.hsync       = w_hsync;
  assign vid.vsync       = w_vsync;
  assign vid.de          = w_h_active && w_v_active;
  assign vid.line_start  = r_line_start;
  assign vid.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share one clock: A = 640x480 defaults, B = tiny 12x7
//   raster with PIX_DIV=1, C = 32x13 raster, active-high syncs, PIX_DIV=3.
//   A reference model tracks each raster as a single linear pixel index and
//   derives every output from it; all outputs are compared every clock.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int B_HA = 8,  B_HFP = 1, B_HS = 2, B_HBP = 1;
  localparam int B_VA = 4,  B_VFP = 1, B_VS = 1, B_VBP = 1, B_DIV = 1;
  localparam int C_HA = 20, C_HFP = 3, C_HS = 4, C_HBP = 5;
  localparam int C_VA = 6,  C_VFP = 2, C_VS = 2, C_VBP = 3, C_DIV = 3;

  localparam int A_XW = clog2(seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP));
  localparam int A_YW = clog2(seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP));
  localparam int B_XW = clog2(seg_total(B_HA, B_HFP, B_HS, B_HBP));
  localparam int B_YW = clog2(seg_total(B_VA, B_VFP, B_VS, B_VBP));
  localparam int C_XW = clog2(seg_total(C_HA, C_HFP, C_HS, C_HBP));
  localparam int C_YW = clog2(seg_total(C_VA, C_VFP, C_VS, C_VBP));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  vga_timing_if #(.X_W(A_XW), .Y_W(A_YW)) vif_a ();
  vga_timing_if #(.X_W(B_XW), .Y_W(B_YW)) vif_b ();
  vga_timing_if #(.X_W(C_XW), .Y_W(C_YW)) vif_c ();

  vga_timing_gen u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .vid (vif_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
    .H_POL (1'b0), .V_POL (1'b0), .PIX_DIV (B_DIV)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .vid (vif_b)
  );

  vga_timing_gen #(
    .H_ACTIVE (C_HA), .H_FP (C_HFP), .H_SYNC (C_HS), .H_BP (C_HBP),
    .V_ACTIVE (C_VA), .V_FP (C_VFP), .V_SYNC (C_VS), .V_BP (C_VBP),
    .H_POL (1'b1), .V_POL (1'b1), .PIX_DIV (C_DIV)
  ) u_dut_c (
    .clk (clk),
    .rst (rst_c),
    .vid (vif_c)
  );

  // ---------------- reference model ----------------
  int cfg_ha  [3] = '{DEF_H_ACTIVE, B_HA,  C_HA};
  int cfg_hfp [3] = '{DEF_H_FP,     B_HFP, C_HFP};
  int cfg_hs  [3] = '{DEF_H_SYNC,   B_HS,  C_HS};
  int cfg_hbp [3] = '{DEF_H_BP,     B_HBP, C_HBP};
  int cfg_va  [3] = '{DEF_V_ACTIVE, B_VA,  C_VA};
  int cfg_vfp [3] = '{DEF_V_FP,     B_VFP, C_VFP};
  int cfg_vs  [3] = '{DEF_V_SYNC,   B_VS,  C_VS};
  int cfg_vbp [3] = '{DEF_V_BP,     B_VBP, C_VBP};
  int cfg_div [3] = '{DEF_PIX_DIV,  B_DIV, C_DIV};
  bit cfg_hpol[3] = '{1'b0, 1'b0, 1'b1};
  bit cfg_vpol[3] = '{1'b0, 1'b0, 1'b1};

  int mp   [3];   // linear pixel index within the frame
  int mclk [3];   // clocks elapsed since the last pixel step
  bit mst  [3];   // a pixel step happened on the latest edge

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  function automatic int h_tot(input int d);
    return seg_total(cfg_ha[d], cfg_hfp[d], cfg_hs[d], cfg_hbp[d]);
  endfunction

  function automatic int v_tot(input int d);
    return seg_total(cfg_va[d], cfg_vfp[d], cfg_vs[d], cfg_vbp[d]);
  endfunction

  task automatic model_reset(input int d);
    mp[d]   = h_tot(d) * v_tot(d) - 1;
    mclk[d] = 0;
    mst[d]  = 1'b0;
  endtask

  task automatic model_step(input int d, input bit r, input bit rs, input bit en);
    if (r) begin
      model_reset(d);
    end else if (rs) begin
      mp[d]   = 0;
      mclk[d] = 0;
      mst[d]  = 1'b1;
    end else if (en) begin
      mclk[d] = mclk[d] + 1;
      if (mclk[d] == cfg_div[d]) begin
        mclk[d] = 0;
        mp[d]   = (mp[d] + 1) % (h_tot(d) * v_tot(d));
        mst[d]  = 1'b1;
      end else begin
        mst[d]  = 1'b0;
      end
    end else begin
      mst[d] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_vec(input int d);
    int x, y;
    bit hs_on, vs_on, de, hs, vs, ls, fs;
    x     = mp[d] % h_tot(d);
    y     = mp[d] / h_tot(d);
    hs_on = (x >= cfg_ha[d] + cfg_hfp[d]) && (x < cfg_ha[d] + cfg_hfp[d] + cfg_hs[d]);
    vs_on = (y >= cfg_va[d] + cfg_vfp[d]) && (y < cfg_va[d] + cfg_vfp[d] + cfg_vs[d]);
    hs    = hs_on ? cfg_hpol[d] : !cfg_hpol[d];
    vs    = vs_on ? cfg_vpol[d] : !cfg_vpol[d];
    de    = (x < cfg_ha[d]) && (y < cfg_va[d]);
    ls    = mst[d] && (x == 0);
    fs    = mst[d] && (mp[d] == 0);
    return {4'b0, fs, ls, de, vs, hs, mst[d], 10'(y), 12'(x)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] obs_a, obs_b, obs_c;
  assign obs_a = {4'b0, vif_a.frame_start, vif_a.line_start, vif_a.de, vif_a.vsync,
                  vif_a.hsync, vif_a.pix_ce, 10'(vif_a.y), 12'(vif_a.x)};
  assign obs_b = {4'b0, vif_b.frame_start, vif_b.line_start, vif_b.de, vif_b.vsync,
                  vif_b.hsync, vif_b.pix_ce, 10'(vif_b.y), 12'(vif_b.x)};
  assign obs_c = {4'b0, vif_c.frame_start, vif_c.line_start, vif_c.de, vif_c.vsync,
                  vif_c.hsync, vif_c.pix_ce, 10'(vif_c.y), 12'(vif_c.x)};

  always @(posedge clk) begin
    model_step(0, rst_a, vif_a.resync, vif_a.en);
    model_step(1, rst_b, vif_b.resync, vif_b.en);
    model_step(2, rst_c, vif_c.resync, vif_c.en);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("vec_a", obs_a, model_vec(0));
      check_eq("vec_b", obs_b, model_vec(1));
      check_eq("vec_c", obs_c, model_vec(2));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, hs_low, de_cnt, period, viol;
    bit found;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    vif_a.en = 1'b1; vif_a.resync = 1'b0;
    vif_b.en = 1'b1; vif_b.resync = 1'b0;
    vif_c.en = 1'b1; vif_c.resync = 1'b0;
    for (int d = 0; d < 3; d++) model_reset(d);

    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    $display("txn reset_release t=%0t", $time);

    // First step lands PIX_DIV clocks after release, on (0,0) with both strobes.
    k = 0; found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (vif_a.pix_ce) begin found = 1'b1; k = i; end
    end
    check_eq("first_ce_clk", k, 2);
    check_eq("first_fs", 32'(vif_a.frame_start), 32'd1);
    check_eq("first_ls", 32'(vif_a.line_start), 32'd1);
    check_eq("first_de", 32'(vif_a.de), 32'd1);
    @(negedge clk);
    check_eq("fs_one_clk", 32'(vif_a.frame_start), 32'd0);
    $display("txn first_step clk=%0d", k);

    // One full line: period, hsync-low and de-high clock counts.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      found = vif_a.line_start;
    end
    check_eq("line_start_seen", 32'(found), 32'd1);
    hs_low = (vif_a.hsync == 1'b0) ? 1 : 0;
    de_cnt = vif_a.de ? 1 : 0;
    period = 0; found = 1'b0;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(negedge clk);
      if (vif_a.line_start) begin
        found = 1'b1; period = i;
      end else begin
        if (vif_a.hsync == 1'b0) hs_low = hs_low + 1;
        if (vif_a.de) de_cnt = de_cnt + 1;
      end
    end
    check_eq("line_period", period, 1600);
    check_eq("hsync_low_clks", hs_low, 192);
    check_eq("de_clks", de_cnt, 1280);
    $display("txn line period=%0d hs_low=%0d de=%0d", period, hs_low, de_cnt);

    // Freeze at x=100 for 10 clocks, then resume at x=101.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = vif_a.pix_ce && (vif_a.x == 100);
    end
    check_eq("reach_x100", 32'(found), 32'd1);
    vif_a.en = 1'b0;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (vif_a.x != 100 || vif_a.pix_ce || vif_a.line_start || vif_a.frame_start)
        viol = viol + 1;
    end
    check_eq("freeze_violations", viol, 0);
    vif_a.en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = vif_a.pix_ce;
    end
    check_eq("resume_x", 32'(vif_a.x), 32'd101);
    $display("txn freeze_resume x=%0d", vif_a.x);

    // resync mid-line, then resync together with en=0.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = vif_a.pix_ce && (vif_a.x == 300);
    end
    check_eq("reach_x300", 32'(found), 32'd1);
    vif_a.resync = 1'b1;
    @(negedge clk);
    vif_a.resync = 1'b0;
    check_eq("resync_xy", {12'(vif_a.y), 12'(vif_a.x)}, 32'd0);
    check_eq("resync_fs", 32'(vif_a.frame_start), 32'd1);
    check_eq("resync_ce", 32'(vif_a.pix_ce), 32'd1);
    check_eq("resync_de", 32'(vif_a.de), 32'd1);
    check_eq("resync_hsync", 32'(vif_a.hsync), 32'd1);
    k = 0; found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (vif_a.pix_ce) begin found = 1'b1; k = i; end
    end
    check_eq("resync_next_step", k, 2);
    vif_a.en = 1'b0;
    vif_a.resync = 1'b1;
    @(negedge clk);
    vif_a.resync = 1'b0;
    check_eq("resync_wins_fs", 32'(vif_a.frame_start), 32'd1);
    check_eq("resync_wins_x", 32'(vif_a.x), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("en0_after_resync_ce", 32'(vif_a.pix_ce), 32'd0);
    vif_a.en = 1'b1;
    $display("txn resync next_step=%0d", k);

    // Asynchronous reset of the tiny raster at (5,2).
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = (vif_b.x == 5) && (vif_b.y == 2);
    end
    check_eq("b_reach_5_2", 32'(found), 32'd1);
    #2;
    rst_b = 1'b1;
    model_reset(1);
    #1;
    check_eq("b_async_x", 32'(vif_b.x), 32'd11);
    check_eq("b_async_y", 32'(vif_b.y), 32'd6);
    check_eq("b_async_de", 32'(vif_b.de), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    $display("txn b_async_reset x=%0d y=%0d", vif_b.x, vif_b.y);

    // Randomised en / resync on all three generators.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      vif_a.en     = ($urandom_range(0, 9) != 0);
      vif_a.resync = ($urandom_range(0, 499) == 0);
      vif_b.en     = ($urandom_range(0, 9) != 0);
      vif_b.resync = ($urandom_range(0, 199) == 0);
      vif_c.en     = ($urandom_range(0, 9) != 0);
      vif_c.resync = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    vif_a.resync = 1'b0; vif_b.resync = 1'b0; vif_c.resync = 1'b0;
    @(negedge clk);
    $display("txn random_phase clks=4000");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
